// File: rtl/frame_scheduler.sv
// Autonomous frame playback scheduler: fires control_trigger, waits for the
// backend completion edge, dwells per table entry, then advances or loops.
module frame_scheduler #(
  parameter int NUM_ENTRIES       = 8,
  parameter int ENTRY_ADDR_LENGTH = 3,
  parameter int DWELL_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES    = 65535
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         cfg_write_n,
  input  logic [ENTRY_ADDR_LENGTH:0]   cfg_address,
  input  logic [DWELL_WIDTH-1:0]       cfg_data,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         update_cycle_complete,
  output logic                         control_trigger,
  output logic                         busy,
  output logic [ENTRY_ADDR_LENGTH-1:0] frame_index,
  output logic                         done,
  output logic                         cfg_reject,
  output logic                         timeout_error
);

  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(TIMEOUT_CYCLES);
  localparam logic [ENTRY_ADDR_LENGTH-1:0] LAST_MAX =
    ENTRY_ADDR_LENGTH'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT,
    DWELL,
    NEXT
  } state_t;

  state_t                       state;
  logic [DWELL_WIDTH-1:0]       dwell_tab [NUM_ENTRIES];
  logic [ENTRY_ADDR_LENGTH-1:0] last_entry;
  logic [7:0]                   loop_count;
  logic [7:0]                   loops_left;
  logic [DWELL_WIDTH-1:0]       dwell_cnt;
  logic [WCW-1:0]               wait_cnt;
  logic                         prev_ucc;

  logic                         cfg_we;
  logic                         cfg_ctrl;
  logic [ENTRY_ADDR_LENGTH-1:0] cfg_idx;
  logic [ENTRY_ADDR_LENGTH-1:0] cfg_last;
  logic [ENTRY_ADDR_LENGTH-1:0] cfg_last_clamped;
  logic                         ucc_rise;

  assign cfg_we   = ~cfg_write_n;
  assign cfg_ctrl = cfg_address[ENTRY_ADDR_LENGTH];
  assign cfg_idx  = cfg_address[ENTRY_ADDR_LENGTH-1:0];
  assign cfg_last = cfg_data[ENTRY_ADDR_LENGTH-1:0];
  assign cfg_last_clamped =
    (int'(cfg_last) > NUM_ENTRIES - 1) ? LAST_MAX : cfg_last;
  assign ucc_rise = update_cycle_complete & ~prev_ucc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) dwell_tab[i] <= '0;
    end else if (cfg_we && !cfg_ctrl && state == IDLE &&
                 int'(cfg_idx) < NUM_ENTRIES) begin
      dwell_tab[cfg_idx] <= cfg_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      last_entry      <= '0;
      loop_count      <= '0;
      loops_left      <= '0;
      dwell_cnt       <= '0;
      wait_cnt        <= '0;
      prev_ucc        <= 1'b0;
      control_trigger <= 1'b0;
      busy            <= 1'b0;
      frame_index     <= '0;
      done            <= 1'b0;
      cfg_reject      <= 1'b0;
      timeout_error   <= 1'b0;
    end else begin
      prev_ucc        <= update_cycle_complete;
      control_trigger <= 1'b0;
      done            <= 1'b0;
      cfg_reject      <= cfg_we && state != IDLE;
      if (cfg_we && cfg_ctrl && state == IDLE) begin
        last_entry <= cfg_last_clamped;
        loop_count <= cfg_data[15:8];
      end
      // Outputs are registered, so the trigger is raised on entry to TRIG.
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              frame_index     <= '0;
              loops_left      <= loop_count;
              timeout_error   <= 1'b0;
              control_trigger <= 1'b1;
              busy            <= 1'b1;
              state           <= TRIG;
            end
          end
          TRIG: begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
          WAIT: begin
            if (ucc_rise) begin
              dwell_cnt <= dwell_tab[frame_index];
              state     <= DWELL;
            end else if (wait_cnt == WAIT_MAX) begin
              timeout_error <= 1'b1;
              busy          <= 1'b0;
              state         <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          DWELL: begin
            if (dwell_cnt == '0) state <= NEXT;
            else dwell_cnt <= dwell_cnt - 1'b1;
          end
          NEXT: begin
            if (frame_index != last_entry) begin
              frame_index     <= frame_index + 1'b1;
              control_trigger <= 1'b1;
              state           <= TRIG;
            end else if (loop_count == '0) begin
              frame_index     <= '0;
              control_trigger <= 1'b1;
              state           <= TRIG;
            end else if (loops_left == 8'd1) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              loops_left      <= loops_left - 1'b1;
              frame_index     <= '0;
              control_trigger <= 1'b1;
              state           <= TRIG;
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: table playback, looping, timeout,
// busy write rejection, level-held completion and async reset.
module tb_frame_scheduler;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int TO = 20;
  localparam logic [AW:0] CTRL = 4'b1000;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_write_n = 1'b1;
  logic [AW:0]   cfg_address = '0;
  logic [DW-1:0] cfg_data = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          update_cycle_complete = 1'b0;
  logic          control_trigger;
  logic          busy;
  logic [AW-1:0] frame_index;
  logic          done;
  logic          cfg_reject;
  logic          timeout_error;

  int n_cmp = 0;
  int n_err = 0;
  int trig_cnt = 0;
  int done_cnt = 0;
  int trig_idx[$];
  time trig_t[$];
  bit resp_en = 1'b0;
  int resp_delay = 2;
  int rd = 0;
  bit ucc_pulse = 1'b0;
  int e;

  frame_scheduler #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .cfg_write_n(cfg_write_n),
    .cfg_address(cfg_address),
    .cfg_data(cfg_data),
    .start(start),
    .stop(stop),
    .update_cycle_complete(update_cycle_complete),
    .control_trigger(control_trigger),
    .busy(busy),
    .frame_index(frame_index),
    .done(done),
    .cfg_reject(cfg_reject),
    .timeout_error(timeout_error)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(negedge clock) begin
    if (control_trigger) begin
      trig_cnt++;
      trig_idx.push_back(int'(frame_index));
      trig_t.push_back($time);
    end
    if (done) done_cnt++;
  end

  // Backend model: one-cycle completion pulse resp_delay cycles after a trigger.
  always @(negedge clock) begin
    if (ucc_pulse) begin
      update_cycle_complete = 1'b0;
      ucc_pulse = 1'b0;
    end
    if (resp_en) begin
      if (control_trigger) rd = resp_delay;
      else if (rd > 0) begin
        rd--;
        if (rd == 0) begin
          update_cycle_complete = 1'b1;
          ucc_pulse = 1'b1;
        end
      end
    end
  end

  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic cfg_wr(logic [AW:0] a, logic [DW-1:0] d);
    cfg_address = a;
    cfg_data = d;
    cfg_write_n = 1'b0;
    step();
    cfg_write_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_log();
    trig_cnt = 0;
    done_cnt = 0;
    trig_idx.delete();
    trig_t.delete();
  endtask

  task automatic wait_idle(string tag, int max);
    for (int i = 0; i < max && busy; i++) step();
    check(tag, 32'(busy), 0);
    step();
  endtask

  task automatic wait_trigs(string tag, int n, int max);
    for (int i = 0; i < max && trig_cnt < n; i++) step();
    check(tag, trig_cnt, n);
  endtask

  function automatic int spacing(int i);
    if (trig_t.size() < i + 2) return -1;
    return int'((trig_t[i+1] - trig_t[i]) / 10);
  endfunction

  function automatic int idx_at(int i);
    if (trig_idx.size() <= i) return -1;
    return trig_idx[i];
  endfunction

  task automatic check_all_zero(string tag);
    check({tag, "_trig"}, 32'(control_trigger), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_idx"}, 32'(frame_index), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_rej"}, 32'(cfg_reject), 0);
    check({tag, "_tmo"}, 32'(timeout_error), 0);
  endtask

  initial begin
    step(3);
    check_all_zero("rst");
    reset_n = 1'b1;
    step();

    // 1: three frames, single pass
    cfg_wr(4'd0, 16'd3);
    cfg_wr(4'd1, 16'd0);
    cfg_wr(4'd2, 16'd5);
    cfg_wr(CTRL, 16'h0102);
    clear_log();
    resp_en = 1'b1;
    pulse_start();
    check("t1_busy", 32'(busy), 1);
    wait_idle("t1_idle", 100);
    check("t1_trigs", trig_cnt, 3);
    check("t1_idx0", idx_at(0), 0);
    check("t1_idx1", idx_at(1), 1);
    check("t1_idx2", idx_at(2), 2);
    check("t1_gap01", spacing(0), 8);
    check("t1_gap12", spacing(1), 5);
    check("t1_done", done_cnt, 1);
    check("t1_hold", 32'(frame_index), 2);

    // 2: loop forever over two frames, then stop
    cfg_wr(CTRL, 16'h0001);
    clear_log();
    pulse_start();
    wait_trigs("t2_trigs", 10, 400);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t2_busy", 32'(busy), 0);
    step();
    check("t2_cnt", trig_cnt, 10);
    check("t2_done", done_cnt, 0);
    for (int i = 0; i < 10; i++)
      check($sformatf("t2_idx%0d", i), idx_at(i), i % 2);

    // 3: no completion -> timeout, restart clears it
    resp_en = 1'b0;
    step(4);
    clear_log();
    pulse_start();
    e = 0;
    while (!timeout_error && e < 200) begin
      step();
      e++;
    end
    check("t3_tmo", 32'(timeout_error), 1);
    check("t3_when", 32'(e >= TO && e <= TO + 3), 1);
    check("t3_busy", 32'(busy), 0);
    step(3);
    check("t3_sticky", 32'(timeout_error), 1);
    check("t3_trigs", trig_cnt, 1);
    resp_en = 1'b1;
    pulse_start();
    check("t3_clr", 32'(timeout_error), 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t3_stop", 32'(busy), 0);

    // 4: writes while busy are rejected and dropped
    resp_en = 1'b0;
    step(4);
    cfg_wr(CTRL, 16'h0101);
    check("t4_idle_rej", 32'(cfg_reject), 0);
    clear_log();
    resp_en = 1'b1;
    pulse_start();
    cfg_address = 4'd0;
    cfg_data = 16'd100;
    cfg_write_n = 1'b0;
    step();
    cfg_write_n = 1'b1;
    check("t4_rej", 32'(cfg_reject), 1);
    step();
    check("t4_rej_end", 32'(cfg_reject), 0);
    wait_idle("t4_idle", 100);
    check("t4_trigs", trig_cnt, 2);
    check("t4_gap", spacing(0), 8);
    check("t4_done", done_cnt, 1);

    // 5: level-held completion is not an edge
    resp_en = 1'b0;
    step(4);
    clear_log();
    update_cycle_complete = 1'b1;
    step(2);
    pulse_start();
    step(6);
    check("t5_stall", trig_cnt, 1);
    check("t5_busy", 32'(busy), 1);
    update_cycle_complete = 1'b0;
    step();
    update_cycle_complete = 1'b1;
    step();
    update_cycle_complete = 1'b0;
    resp_en = 1'b1;
    wait_idle("t5_idle", 100);
    check("t5_trigs", trig_cnt, 2);
    check("t5_idx1", idx_at(1), 1);
    check("t5_done", done_cnt, 1);

    // 6: async reset during dwell, then start+stop together
    cfg_wr(4'd1, 16'd6);
    clear_log();
    pulse_start();
    for (int i = 0; i < 60 && !(control_trigger && frame_index == 1); i++)
      step();
    check("t6_frame1", 32'(frame_index), 1);
    step(4);
    check("t6_pre_busy", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("t6_rst");
    resp_en = 1'b0;
    step();
    rd = 0;
    reset_n = 1'b1;
    step();
    cfg_wr(CTRL, 16'h0100);
    clear_log();
    resp_en = 1'b1;
    pulse_start();
    e = 0;
    while (busy && e < 100) begin
      step();
      e++;
    end
    check("t6_tab_clr", e, 5);
    step();
    check("t6_done", done_cnt, 1);
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    check("t6_ss_busy", 32'(busy), 0);
    check("t6_ss_trig", 32'(control_trigger), 0);
    step();
    check("t6_ss_busy2", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
